// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, status flag bit positions and the
// state type of the iterative multiply/divide sequencer.
package alu_pkg;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_SLT = 5'b00010;
  localparam logic [4:0] ALU_MUL = 5'b00011;
  localparam logic [4:0] ALU_DIV = 5'b00100;
  localparam logic [4:0] ALU_AND = 5'b00101;
  localparam logic [4:0] ALU_OR  = 5'b00110;
  localparam logic [4:0] ALU_XOR = 5'b00111;
  localparam logic [4:0] ALU_SLL = 5'b01000;
  localparam logic [4:0] ALU_SRL = 5'b01001;
  localparam logic [4:0] ALU_SRA = 5'b01010;
  localparam logic [4:0] ALU_BEQ = 5'b01011;
  localparam logic [4:0] ALU_BNE = 5'b01100;

  localparam int unsigned FLAG_ZERO = 0;
  localparam int unsigned FLAG_DIVZ = 1;
  localparam int unsigned FLAG_OVF  = 2;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath: unsigned shift-add for MUL,
// restoring subtract-compare for DIV.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 op_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [2*WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]     opb,
  output logic [2*WIDTH-1:0]   acc_next,
  output logic [2*WIDTH-1:0]   mcand_next,
  output logic [WIDTH-1:0]     opb_next
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // DIV packs {remainder, dividend/quotient} into acc; quotient bits enter at the bottom.
  always_comb begin
    rem_sh     = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff       = rem_sh - {1'b0, opb};
    acc_next   = acc;
    mcand_next = mcand;
    opb_next   = opb;
    if (op_div) begin
      if (diff[WIDTH]) begin
        acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
        acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_next   = acc + (opb[0] ? mcand : '0);
      mcand_next = mcand << 1;
      opb_next   = opb >> 1;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative MUL/DIV sequencer for the EX stage: one bit per cycle, with a
// combinational stall to the hazard unit and a one-cycle done pulse.
module muldiv_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       alu_control,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flag
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  muldiv_state_t      state_q;
  logic [CntW-1:0]    count_q;
  logic               op_div_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   opb_q;

  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] mcand_next;
  logic [WIDTH-1:0]   opb_next;

  logic       is_mul;
  logic       is_div;
  logic       accept;
  logic       last_iter;
  logic [3:0] calc_flag;
  logic [3:0] divz_flag;

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .op_div    (op_div_q),
    .acc       (acc_q),
    .mcand     (mcand_q),
    .opb       (opb_q),
    .acc_next  (acc_next),
    .mcand_next(mcand_next),
    .opb_next  (opb_next)
  );

  always_comb begin
    is_mul    = (alu_control == ALU_MUL);
    is_div    = (alu_control == ALU_DIV);
    accept    = (state_q == StIdle) && start && (is_mul || is_div) && !flush;
    stall     = accept || (state_q == StCalc);
    last_iter = (count_q == CntW'(WIDTH - 1));
    // Both MUL product and DIV quotient sit in the low half of acc.
    calc_flag            = '0;
    calc_flag[FLAG_ZERO] = (acc_next[WIDTH-1:0] == '0);
    calc_flag[FLAG_OVF]  = !op_div_q && (acc_next[2*WIDTH-1:WIDTH] != '0);
    divz_flag            = '0;
    divz_flag[FLAG_DIVZ] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      count_q  <= '0;
      op_div_q <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      opb_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      flag     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            busy <= 1'b1;
            if (is_div && (data_b == '0)) begin
              result  <= '1;
              flag    <= divz_flag;
              done    <= 1'b1;
              state_q <= StDone;
            end else begin
              op_div_q <= is_div;
              acc_q    <= is_div ? {{WIDTH{1'b0}}, data_a} : '0;
              mcand_q  <= {{WIDTH{1'b0}}, data_a};
              opb_q    <= data_b;
              count_q  <= '0;
              state_q  <= StCalc;
            end
          end
        end
        StCalc: begin
          if (flush) begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end else begin
            acc_q   <= acc_next;
            mcand_q <= mcand_next;
            opb_q   <= opb_next;
            count_q <= count_q + CntW'(1);
            if (last_iter) begin
              result  <= acc_next[WIDTH-1:0];
              flag    <= calc_flag;
              done    <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: directed cases plus random MUL/DIV traffic
// checked against a plain-arithmetic reference model.
module tb_muldiv_ctrl;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [4:0]   alu_control = ALU_ADD;
  logic [W-1:0] data_a = '0;
  logic [W-1:0] data_b = '0;
  logic         flush = 1'b0;
  logic         stall;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [3:0]   flag;

  int checks = 0;
  int errors = 0;
  logic [35:0] exp_q[$];
  logic [W-1:0] last_res = '0;
  logic [3:0]   last_flag = '0;
  bit done_prev = 1'b0;

  muldiv_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .alu_control(alu_control),
    .data_a     (data_a),
    .data_b     (data_b),
    .flush      (flush),
    .stall      (stall),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .flag       (flag)
  );

  always #5 clk = ~clk;

  function automatic logic [35:0] model(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    logic [3:0]  f;
    f = '0;
    if (op == ALU_MUL) begin
      p    = {32'd0, a} * {32'd0, b};
      r    = p[31:0];
      f[2] = (p[63:32] != 0);
    end else if (b == 0) begin
      r    = 32'hFFFF_FFFF;
      f[1] = 1'b1;
    end else begin
      r = a / b;
    end
    f[0] = (r == 0);
    return {f, r};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [35:0] e;
    if (done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done actual=%0h/%0h required=none", flag, result);
      end else begin
        e = exp_q.pop_front();
        if ({flag, result} !== e) begin
          errors++;
          $display("FAIL done_value actual=%0h/%08h required=%0h/%08h",
                   flag, result, e[35:32], e[31:0]);
        end
      end
    end
    if (done_prev) begin
      checks++;
      if (done) begin
        errors++;
        $display("FAIL done_twice actual=1 required=0");
      end
    end
    done_prev = done;
  end

  // Entered and left at #1 after a posedge; the start cycle is the entry cycle.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [35:0] e;
    int lat, sc, bc, exp_lat;
    e = model(op, a, b);
    exp_lat = (op == ALU_DIV && b == 0) ? 1 : W + 1;
    start = 1'b1;
    alu_control = op;
    data_a = a;
    data_b = b;
    exp_q.push_back(e);
    lat = -1;
    sc = 0;
    bc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (stall) sc++;
      if (busy) bc++;
      if (done) begin
        lat = k;
        break;
      end
      @(posedge clk);
      #1;
      // Bus noise while busy must not be re-latched.
      start = 1'($urandom_range(0, 1));
      data_a = $urandom;
      data_b = $urandom;
    end
    if (lat < 0) $display("FAIL done_timeout actual=none required=%0d", exp_lat);
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("stall_cycles", 64'(sc), 64'(exp_lat));
    chk("busy_cycles", 64'(bc), 64'(exp_lat));
    last_res = e[31:0];
    last_flag = e[35:32];
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic bypass_op(input logic [4:0] op);
    start = 1'b1;
    alu_control = op;
    data_a = $urandom;
    data_b = $urandom;
    #1;
    chk("bypass_stall", 64'(stall), 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("bypass_busy", 64'(busy), 0);
    chk("bypass_result_hold", 64'({flag, result}), 64'({last_flag, last_res}));
  endtask

  initial begin
    logic [31:0] a, b;
    int sel;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({busy, done, flag, result}), 0);
    chk("reset_stall", 64'(stall), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_op(ALU_MUL, 32'd7, 32'd6);
    run_op(ALU_MUL, 32'h0001_0000, 32'h0001_0000);
    run_op(ALU_DIV, 32'd100, 32'd7);
    run_op(ALU_DIV, 32'd3, 32'd9);
    run_op(ALU_DIV, 32'd5, 32'd0);

    // Flush a MUL in CALC at T+10.
    start = 1'b1;
    alu_control = ALU_MUL;
    data_a = 32'd3;
    data_b = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 0);
    chk("flush_done", 64'(done), 0);
    chk("flush_stall", 64'(stall), 0);
    chk("flush_hold", 64'({flag, result}), 64'({last_flag, last_res}));
    run_op(ALU_MUL, 32'hFFFF_FFFF, 32'd2);

    bypass_op(ALU_ADD);

    // flush with start in IDLE: nothing accepted.
    start = 1'b1;
    flush = 1'b1;
    alu_control = ALU_DIV;
    data_a = 32'd9;
    data_b = 32'd0;
    #1;
    chk("idle_flush_stall", 64'(stall), 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    chk("idle_flush_busy", 64'(busy), 0);
    @(posedge clk);
    #1;
    chk("idle_flush_hold", 64'({done, flag, result}), 64'({1'b0, last_flag, last_res}));

    // Reset at T+5 of a DIV.
    start = 1'b1;
    alu_control = ALU_DIV;
    data_a = 32'd100;
    data_b = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_outputs", 64'({busy, done, flag, result}), 0);
    chk("midreset_stall", 64'(stall), 0);
    reset = 1'b0;
    last_res = '0;
    last_flag = '0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 9);
      a = $urandom >> $urandom_range(0, 31);
      b = $urandom >> $urandom_range(0, 31);
      if (sel < 4) run_op(ALU_MUL, a, b);
      else if (sel < 8) run_op(ALU_DIV, a, b);
      else if (sel == 8) run_op(ALU_DIV, a, 32'd0);
      else bypass_op(5'($urandom_range(5, 12)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 64'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
